i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter TARGET_ADDRESS, default 7'h3c, 7-bit bus address this target answers.
REQ-002 SHALL have port clk input 1: system clock; all logic sampled on posedge.
REQ-003 SHALL have port rst_n input 1: asynchronous, active-low reset.
REQ-004 SHALL have port sclIn input 1: bus SCL level, asynchronous to clk.
REQ-005 SHALL have port sdaIn input 1: bus SDA level, asynchronous to clk.
REQ-006 SHALL have port sdaPullLow output 1: 1 drives SDA low (open drain); 0 releases SDA to Z at the pad.
REQ-007 SHALL have port rxData output 8: last byte written by the initiator.
REQ-008 SHALL have port rxValid output 1: one-cycle pulse when rxData updates.
REQ-009 SHALL have port txData input 8: byte to return on a read; sampled at load points.
REQ-010 SHALL have port txLoad output 1: one-cycle pulse when txData is sampled.
REQ-011 SHALL have port busy output 1: high from an address match to STOP or NACK release.

Function
REQ-012 SHALL pass sclIn and sdaIn each through a 2-flop synchronizer; a third register per line provides edge detection.
REQ-013 SHALL detect START as synchronized SDA 1->0 while SCL is high, and STOP as SDA 0->1 while SCL is high.
REQ-014 SHALL use states IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
REQ-015 SHALL enter ADDR on START from any state, including a repeated START; entry clears the bit counter and releases SDA.
REQ-016 SHALL enter IDLE on STOP from any state, release SDA, and drop busy.
REQ-017 SHALL sample SDA on SCL rising edges only, MSB first, and change sdaPullLow on SCL falling edges only.
REQ-018 ADDR: after 8 bits, if bits[7:1]==TARGET_ADDRESS, SHALL assert sdaPullLow on the next SCL fall, set busy, and go to ADDR_ACK; otherwise SHALL go to WAIT_STOP with SDA released.
REQ-019 ADDR_ACK: on the following SCL fall (end of the 9th clock), SHALL go to WRITE if R/W=0, releasing SDA; if R/W=1 SHALL sample txData, pulse txLoad, drive bit 7, and go to READ.
REQ-020 WRITE: on the 8th rising edge SHALL update rxData, pulse rxValid in the next clk cycle, and ACK on the next SCL fall (WRITE_ACK); the release on the 9th fall returns to WRITE.
REQ-021 READ: SHALL drive sdaPullLow = ~bit on each SCL fall for bits 6..0; after bit 0 is clocked, SHALL release SDA on the next fall and go to READ_ACK.
REQ-022 READ_ACK: SHALL sample initiator SDA on the 9th rising edge; on 0 (ACK), at the next fall SHALL load txData, pulse txLoad, and resume READ; on 1 (NACK) SHALL go to WAIT_STOP.
REQ-023 WAIT_STOP: SHALL keep SDA released and ignore data until START or STOP.
REQ-024 The bit counter SHALL be 3 bits and wrap 7->0 at each byte boundary.
REQ-025 rxValid and txLoad SHALL never assert in the same cycle; each SHALL be exactly one clk wide.
REQ-026 If START and STOP conditions appear in the same cycle (glitch), STOP SHALL win.
REQ-027 sdaPullLow SHALL be registered, with no combinational path from inputs.
REQ-028 The clk frequency SHALL be at least 8x the SCL frequency; behaviour below that ratio is undefined.

Reset
REQ-029 While rst_n is low, SHALL hold: state IDLE, sdaPullLow 0, rxData 8'h00, rxValid 0, txLoad 0, busy 0, synchronizer flops 1.
REQ-030 Reset asserted mid-transfer SHALL release SDA immediately, combinationally via the asynchronous clear.
REQ-031 After rst_n deasserts, SHALL ignore bus activity until the first START.

Verification
REQ-032 Write: START, 0x78, 0xA5, STOP -> ACK on both 9th clocks, one rxValid with rxData=0xA5, busy low after STOP.
REQ-033 Mismatch: START, 0x7A, 0x55, STOP -> SDA never driven; no rxValid; busy stays 0.
REQ-034 Read: START, 0x79, txData=0xC3 then 0x3C, initiator ACK then NACK, STOP -> bus carries 0xC3 then 0x3C; two txLoad pulses; SDA released after NACK.
REQ-035 Repeated START: START, 0x78, 0x01, START, 0x79, read 1 byte with NACK, STOP -> rxData=0x01, then txData byte returned, busy stays high across the repeated START.
REQ-036 rst_n pulsed low while the target drives ACK -> sdaPullLow 0 in the same cycle; the next write transaction behaves as in REQ-032.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target (slave) with 7-bit addressing, single-byte write/read data path and an
// open-drain SDA pull-down. SCL/SDA are oversampled by clk (clk >= 8x SCL).
module i2c_target #(
  parameter logic [6:0] TARGET_ADDRESS = 7'h3c
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclIn,
  input  logic       sdaIn,
  output logic       sdaPullLow,
  output logic [7:0] rxData,
  output logic       rxValid,
  input  logic [7:0] txData,
  output logic       txLoad,
  output logic       busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] WRITE     = 3'd3;
  localparam logic [2:0] WRITE_ACK = 3'd4;
  localparam logic [2:0] READ      = 3'd5;
  localparam logic [2:0] READ_ACK  = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  // [0],[1] synchronize; [2] holds the previous synchronized level for edge detection.
  logic [2:0] scl_sync_q, scl_sync_d;
  logic [2:0] sda_sync_q, sda_sync_d;
  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_pull_q, sda_pull_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       busy_q, busy_d;
  logic       pend_q, pend_d;

  logic       scl_s, scl_prev, sda_s, sda_prev;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  assign scl_s     = scl_sync_q[1];
  assign scl_prev  = scl_sync_q[2];
  assign sda_s     = sda_sync_q[1];
  assign sda_prev  = sda_sync_q[2];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;
  assign rx_byte   = {shift_q[6:0], sda_s};

  // pend_q marks "byte/ACK bit seen on the rising edge, act on the next falling edge".
  always_comb begin
    // NOTE: every *_d starts from its *_q (or an idle pulse value) so no path leaves it unassigned and no latch is inferred.
    scl_sync_d = {scl_sync_q[1:0], sclIn};
    sda_sync_d = {sda_sync_q[1:0], sdaIn};
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    sda_pull_d = sda_pull_q;
    busy_d     = busy_q;
    pend_d     = pend_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;

    if (stop_det) begin
      state_d    = IDLE;
      sda_pull_d = 1'b0;
      busy_d     = 1'b0;
      pend_d     = 1'b0;
    end else if (start_det) begin
      state_d    = ADDR;
      bit_cnt_d  = 3'd0;
      sda_pull_d = 1'b0;
      pend_d     = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] == TARGET_ADDRESS) begin
                pend_d = 1'b1;
              end else begin
                state_d = WAIT_STOP;
                busy_d  = 1'b0;
              end
            end
          end else if (scl_fall && pend_q) begin
            pend_d     = 1'b0;
            sda_pull_d = 1'b1;
            busy_d     = 1'b1;
            state_d    = ADDR_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 3'd0;
            if (shift_q[0]) begin
              shift_d    = txData;
              tx_load_d  = 1'b1;
              sda_pull_d = ~txData[7];
              state_d    = READ;
            end else begin
              sda_pull_d = 1'b0;
              state_d    = WRITE;
            end
          end
        end
        WRITE: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
              pend_d     = 1'b1;
            end
          end else if (scl_fall && pend_q) begin
            pend_d     = 1'b0;
            sda_pull_d = 1'b1;
            state_d    = WRITE_ACK;
          end
        end
        WRITE_ACK: begin
          if (scl_fall) begin
            sda_pull_d = 1'b0;
            state_d    = WRITE;
          end
        end
        READ: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) pend_d = 1'b1;
          end else if (scl_fall) begin
            if (pend_q) begin
              pend_d     = 1'b0;
              sda_pull_d = 1'b0;
              state_d    = READ_ACK;
            end else begin
              shift_d    = {shift_q[6:0], 1'b0};
              sda_pull_d = ~shift_q[6];
            end
          end
        end
        READ_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              pend_d = 1'b1;
            end else begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && pend_q) begin
            pend_d     = 1'b0;
            bit_cnt_d  = 3'd0;
            shift_d    = txData;
            tx_load_d  = 1'b1;
            sda_pull_d = ~txData[7];
            state_d    = READ;
          end
        end
        default: ;  // IDLE and WAIT_STOP only react to START/STOP
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      sda_pull_q <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      busy_q     <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      sda_pull_q <= sda_pull_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      busy_q     <= busy_d;
      pend_q     <= pend_d;
    end
  end

  assign sdaPullLow = sda_pull_q;
  assign rxData     = rx_data_q;
  assign rxValid    = rx_valid_q;
  assign txLoad     = tx_load_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged initiator on a wired-AND SDA line,
// a table of single-transaction vectors, and hand sequences for multi-byte corners.
module tb_i2c_target;

  logic       clk;
  logic       rst_n;
  logic       scl_m;
  logic       sda_m;
  logic       sdaPullLow;
  logic [7:0] rxData;
  logic       rxValid;
  logic [7:0] txData;
  logic       txLoad;
  logic       busy;
  logic       sda_line;

  assign sda_line = sda_m & ~sdaPullLow;

  i2c_target #(.TARGET_ADDRESS(7'h3c)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclIn      (scl_m),
    .sdaIn      (sda_line),
    .sdaPullLow (sdaPullLow),
    .rxData     (rxData),
    .rxValid    (rxValid),
    .txData     (txData),
    .txLoad     (txLoad),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Output activity counters, sampled on the non-active edge.
  int rx_cycles = 0;
  int tx_cycles = 0;
  int drv_cycles = 0;
  int busy_cycles = 0;
  int overlap_cycles = 0;

  always @(negedge clk) begin
    if (rxValid) rx_cycles <= rx_cycles + 1;
    if (txLoad) tx_cycles <= tx_cycles + 1;
    if (sdaPullLow) drv_cycles <= drv_cycles + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
    if (rxValid && txLoad) overlap_cycles <= overlap_cycles + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_cond();
    sda_m = 1'b1; tick(4);
    scl_m = 1'b1; tick(8);
    sda_m = 1'b0; tick(8);
    scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    tick(4); sda_m = 1'b0; tick(4);
    scl_m = 1'b1; tick(8);
    sda_m = 1'b1; tick(8);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      tick(4); sda_m = b[i]; tick(4);
      scl_m = 1'b1; tick(8);
      scl_m = 1'b0;
    end
  endtask

  task automatic ack_clock(output logic a);
    tick(4); sda_m = 1'b1; tick(4);
    scl_m = 1'b1; tick(4);
    a = sda_line; tick(4);
    scl_m = 1'b0;
  endtask

  // Reads 8 bits from the target, then drives ack_bit (0 = ACK) on the 9th clock.
  task automatic recv_byte(output logic [7:0] b, input logic ack_bit, input logic [7:0] next_tx);
    for (int i = 7; i >= 0; i--) begin
      tick(4); sda_m = 1'b1; tick(4);
      scl_m = 1'b1; tick(4);
      b[i] = sda_line; tick(4);
      scl_m = 1'b0;
    end
    txData = next_tx;
    tick(4); sda_m = ack_bit; tick(4);
    scl_m = 1'b1; tick(8);
    scl_m = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] tx;
    logic       exp_ack0;
    logic       exp_ack1;
    logic [7:0] exp_rd;
    int         exp_rx;
    logic [7:0] exp_rxdata;
    int         exp_tx;
    logic       exp_drv;
  } vec_t;

  vec_t       vecs[7];
  logic       a0, a1;
  logic [7:0] rd, rd2;
  int         rx0, tx0, dr0, bz0;
  logic       got;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h78, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h00, 1, 8'hA5, 0, 1'b1};
    vecs[1] = '{8'h7A, 8'h55, 8'h00, 1'b1, 1'b1, 8'h00, 0, 8'hA5, 0, 1'b0};
    vecs[2] = '{8'h79, 8'h00, 8'h96, 1'b0, 1'b1, 8'h96, 0, 8'hA5, 1, 1'b1};
    vecs[3] = '{8'h78, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1, 8'h00, 0, 1'b1};
    vecs[4] = '{8'h7D, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 0, 8'h00, 0, 1'b0};
    vecs[5] = '{8'h79, 8'h00, 8'hFF, 1'b0, 1'b1, 8'hFF, 0, 8'h00, 1, 1'b1};
    vecs[6] = '{8'h78, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1, 8'hFF, 0, 1'b1};

    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; txData = 8'h00;
    tick(3);
    check("reset_sdaPullLow", sdaPullLow, 0);
    check("reset_rxData", rxData, 8'h00);
    check("reset_rxValid", rxValid, 0);
    check("reset_txLoad", txLoad, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    tick(4);

    // Clock a matching address without a START: must be ignored.
    dr0 = drv_cycles; rx0 = rx_cycles;
    scl_m = 1'b0; tick(4);
    send_bits(8'h78);
    ack_clock(a0);
    check("no_start_ack", a0, 1'b1);
    check("no_start_drive", drv_cycles - dr0, 0);
    sda_m = 1'b0; tick(4); scl_m = 1'b1; tick(4); sda_m = 1'b1; tick(8);

    for (int v = 0; v < 7; v++) begin
      txData = vecs[v].tx;
      rx0 = rx_cycles; tx0 = tx_cycles; dr0 = drv_cycles; bz0 = busy_cycles;
      start_cond();
      send_bits(vecs[v].b0);
      ack_clock(a0);
      check($sformatf("v%0d_addr_ack", v), a0, vecs[v].exp_ack0);
      if (vecs[v].b0[0]) begin
        recv_byte(rd, 1'b1, vecs[v].tx);
        check($sformatf("v%0d_read_byte", v), rd, vecs[v].exp_rd);
      end else begin
        send_bits(vecs[v].b1);
        ack_clock(a1);
        check($sformatf("v%0d_data_ack", v), a1, vecs[v].exp_ack1);
      end
      stop_cond();
      check($sformatf("v%0d_rxData", v), rxData, vecs[v].exp_rxdata);
      check($sformatf("v%0d_rxValid_cycles", v), rx_cycles - rx0, vecs[v].exp_rx);
      check($sformatf("v%0d_txLoad_cycles", v), tx_cycles - tx0, vecs[v].exp_tx);
      check($sformatf("v%0d_sda_driven", v), (drv_cycles - dr0) > 0, vecs[v].exp_drv);
      check($sformatf("v%0d_busy_seen", v), (busy_cycles - bz0) > 0, vecs[v].exp_drv);
      check($sformatf("v%0d_busy_after_stop", v), busy, 0);
      check($sformatf("v%0d_sda_released", v), sdaPullLow, 0);
    end

    // Two-byte read: ACK after 0xC3, NACK after 0x3C.
    txData = 8'hC3;
    tx0 = tx_cycles;
    start_cond();
    send_bits(8'h79);
    ack_clock(a0);
    check("rd2_addr_ack", a0, 1'b0);
    recv_byte(rd, 1'b0, 8'h3C);
    recv_byte(rd2, 1'b1, 8'h3C);
    tick(4);
    check("rd2_byte0", rd, 8'hC3);
    check("rd2_byte1", rd2, 8'h3C);
    check("rd2_txLoad_cycles", tx_cycles - tx0, 2);
    check("rd2_released_after_nack", sdaPullLow, 0);
    check("rd2_busy_after_nack", busy, 0);
    stop_cond();

    // Write 0x01, repeated START, read one byte with NACK.
    txData = 8'h5A;
    rx0 = rx_cycles; tx0 = tx_cycles;
    start_cond();
    send_bits(8'h78); ack_clock(a0);
    send_bits(8'h01); ack_clock(a1);
    check("rs_write_acks", {a0, a1}, 2'b00);
    check("rs_rxData", rxData, 8'h01);
    check("rs_busy_before", busy, 1);
    start_cond();
    check("rs_busy_after_restart", busy, 1);
    send_bits(8'h79); ack_clock(a0);
    check("rs_read_addr_ack", a0, 1'b0);
    recv_byte(rd, 1'b1, 8'h5A);
    check("rs_read_byte", rd, 8'h5A);
    stop_cond();
    check("rs_busy_after_stop", busy, 0);
    check("rs_rxValid_cycles", rx_cycles - rx0, 1);
    check("rs_txLoad_cycles", tx_cycles - tx0, 1);

    // Reset pulse while the target drives the address ACK.
    start_cond();
    send_bits(8'h78);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (sdaPullLow) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_ack_driven_before", got, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("rst_sda_released_now", sdaPullLow, 0);
    check("rst_busy_cleared", busy, 0);
    tick(3);
    scl_m = 1'b1; sda_m = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    rx0 = rx_cycles;
    start_cond();
    send_bits(8'h78); ack_clock(a0);
    send_bits(8'hA5); ack_clock(a1);
    check("post_rst_acks", {a0, a1}, 2'b00);
    stop_cond();
    check("post_rst_rxData", rxData, 8'hA5);
    check("post_rst_rxValid_cycles", rx_cycles - rx0, 1);
    check("post_rst_busy", busy, 0);

    check("no_rx_tx_overlap", overlap_cycles, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
